// File: rtl/wall_collision_checker.sv
// Wall collision query against the full-map tile ROM: walks the tile rows
// under the car bounding box one per cycle and reports any wall tile hit.
module wall_collision_checker #(
  parameter int TILE_SHIFT = 3,
  parameter int CAR_SIZE   = 16,
  parameter int MAP_COLS   = 80,
  parameter int MAP_ROWS   = 60,
  parameter int MAP2_BASE  = 70,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                start,
  input  logic                map_sel,
  input  logic [9:0]          pos_x,
  input  logic [9:0]          pos_y,
  output logic [10:0]         rom_addr,
  input  logic [MAP_COLS-1:0] rom_data,
  output logic                busy,
  output logic                done,
  output logic                blocked,
  output logic [1:0]          dbg_state
);

  // Handshake: start is a level request honoured only in IDLE; done is a
  // single-cycle result strobe and blocked is valid from then until the next accept.

  localparam int CW = $clog2(MAP_COLS);
  localparam int RW = $clog2(MAP_ROWS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [10:0]   x_end, y_end;
  logic          oob;
  logic          map_q;
  logic [CW-1:0] c0_q, c1_q;
  logic [RW-1:0] r_q, r1_q;
  logic          hit;
  logic          last_row;

  // 11-bit sums so a box hanging past the screen edge cannot wrap back in range
  assign x_end    = {1'b0, pos_x} + 11'(CAR_SIZE - 1);
  assign y_end    = {1'b0, pos_y} + 11'(CAR_SIZE - 1);
  assign oob      = (x_end > 11'(SCREEN_W - 1)) || (y_end > 11'(SCREEN_H - 1));
  assign last_row = (r_q == r1_q);

  // Column c of the ROM row sits at bit MAP_COLS-1-c
  always_comb begin
    hit = 1'b0;
    for (int c = 0; c < MAP_COLS; c++) begin
      if (c >= int'(c0_q) && c <= int'(c1_q)) begin
        hit = hit | rom_data[MAP_COLS-1-c];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = oob ? DONE : SCAN;
      SCAN: if (hit || last_row) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      blocked <= 1'b0;
      map_q   <= 1'b0;
      c0_q    <= '0;
      c1_q    <= '0;
      r_q     <= '0;
      r1_q    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            map_q   <= map_sel;
            c0_q    <= CW'(pos_x >> TILE_SHIFT);
            c1_q    <= CW'(x_end >> TILE_SHIFT);
            r_q     <= RW'(pos_y >> TILE_SHIFT);
            r1_q    <= RW'(y_end >> TILE_SHIFT);
            blocked <= oob;
          end
        end
        SCAN: begin
          if (hit) begin
            blocked <= 1'b1;
          end else if (last_row) begin
            blocked <= 1'b0;
          end else begin
            r_q <= r_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rom_addr = '0;
    if (state == SCAN) begin
      rom_addr = (map_q ? 11'(MAP2_BASE) : 11'd0) + 11'(r_q);
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: doc/wall_collision_checker.md
Name: wall_collision_checker

Overview:
- Sequential consumer of the full-map tile ROM; sits directly downstream of it.
- Given a proposed car top-left pixel position and a map select, scans the ROM rows covered by the car's bounding box and reports whether any covered tile is a wall.
- Used by the player/enemy car movement logic before committing a move: one query per frame per car.
- Map is 80 columns x 60 rows of 8x8-pixel tiles (640x480); map 1 rows live at ROM address 0, map 2 rows at ROM address 70.

Parameters:
- TILE_SHIFT, 3, log2 of tile size in pixels
- CAR_SIZE, 16, car bounding box edge length in pixels
- MAP_COLS, 80, tiles per row
- MAP_ROWS, 60, rows per map
- MAP2_BASE, 70, ROM row address of map 2 row 0
- SCREEN_W, 640, pixel width
- SCREEN_H, 480, pixel height

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous active-high reset
- start  in  1  query request; sampled only in IDLE
- map_sel  in  1  0 = map 1, 1 = map 2; latched on accepted start
- pos_x  in  10  proposed car left pixel; latched on accepted start
- pos_y  in  10  proposed car top pixel; latched on accepted start
- rom_addr  out  11  row address to tile ROM (combinational ROM, data valid same cycle)
- rom_data  in  80  ROM row; column c is rom_data[79-c]; 1 = wall
- busy  out  1  high in SCAN and DONE
- done  out  1  one-cycle pulse; result valid
- blocked  out  1  query result; holds until next accepted start

Behaviour:
- Reset: state IDLE; busy=0, done=0, blocked=0, rom_addr=0. Reset in any state aborts the query with no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 latches the inputs, computes c0=x>>3, c1=(x+CAR_SIZE-1)>>3, r0=y>>3, r1=(y+CAR_SIZE-1)>>3, and clears blocked.
  - Sums are computed at 11 bits, so there is no wrap.
- Out-of-bounds check at start:
  - Condition: x+CAR_SIZE-1 > 639 or y+CAR_SIZE-1 > 479.
  - Go directly to DONE with blocked=1; no SCAN cycle.
- Otherwise go to SCAN with row pointer r=r0.
- SCAN, one ROM row per cycle:
  - rom_addr = (map_sel ? MAP2_BASE : 0) + r.
  - hit = OR of rom_data[79-c] for c in c0..c1 (2 or 3 columns).
  - If hit: blocked<=1, go to DONE (early exit).
  - Else if r==r1: blocked<=0, go to DONE.
  - Else r<=r+1.
- rom_addr is 0 in IDLE and DONE.
- DONE: done=1 for exactly one cycle, then IDLE. blocked stays stable from the DONE cycle until the next accepted start.
- Latency, start accepted at cycle T:
  - In-bounds: done at T+1+N, where N = rows scanned (1..3; early exit shortens N).
  - Out-of-bounds: done at T+1.
- start while busy is ignored; no queueing. start in the DONE cycle is also ignored.
- map_sel/pos changes after acceptance have no effect on the query in flight.

Test Plan:
- Free position, clear tiles: map_sel=0, pos=(8,8) -> rom_addr 1 then 2, no hit, done at T+3, blocked=0.
- Top border hit: map_sel=0, pos=(0,0) -> rom_addr 0, row all walls, early exit, done at T+2, blocked=1.
- Unaligned box, 3 rows x 3 cols: map_sel=0, pos=(9,9) -> rom_addr 1, 2, 3; hit on row 3 column 3; done at T+4, blocked=1.
- Map 2 offset: map_sel=1, pos=(40,24) -> first rom_addr=73; column 6 is a wall; done at T+2, blocked=1.
- Out of bounds: pos=(630,100) -> no SCAN, rom_addr stays 0, done at T+1, blocked=1; pos=(0,470) gives the same response.
- Robustness:
  - start pulsed during SCAN is ignored: exactly one done pulse, and blocked keeps the first query's result.
  - Reset asserted mid-SCAN: next cycle busy=0, blocked=0, rom_addr=0, no done pulse.
